// File: rtl/i2s_pkg.sv
// -----------------------------------------------------------------------------
// i2s_pkg
// Shared definitions for the I2S transmitter slice.
//   SLOT_W      : SCK periods per channel slot (fixed at 32).
//   FRAME_SLOTS : SCK periods per stereo frame (left + right).
//   SLOT_IDX_W  : width of the per-frame slot index.
//   BIT_W       : width of a bit position inside one slot.
//   state_e     : transmitter run state.
//   fifo_aw()   : address width of a power-of-two FIFO of the given depth.
// -----------------------------------------------------------------------------
package i2s_pkg;

  localparam int SLOT_W      = 32;
  localparam int FRAME_SLOTS = 64;
  localparam int SLOT_IDX_W  = $clog2(FRAME_SLOTS);
  localparam int BIT_W       = $clog2(SLOT_W);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic int fifo_aw(input int depth);
    return $clog2(depth);
  endfunction

endpackage : i2s_pkg

// File: rtl/i2s_tx_fifo.sv
// -----------------------------------------------------------------------------
// i2s_tx_fifo
// Synchronous FIFO holding stereo sample pairs for the I2S transmitter.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   flush_i       : clear all entries; wins over a same-cycle push or pop
//   push_i        : write wr_data_i (ignored while full)
//   pop_i         : advance the read pointer (ignored while empty)
//   wr_data_i     : entry to write
//   rd_data_o     : entry at the head (valid while !empty_o)
//   level_o       : number of entries held
//   full_o        : level_o == DEPTH
//   empty_o       : level_o == 0
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module i2s_tx_fifo
  import i2s_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic [fifo_aw(DEPTH):0]    level_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = fifo_aw(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      level;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (level == (AW+1)'(DEPTH));
  assign empty_o = (level == '0);
  assign level_o = level;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign rd_data_o = mem[rd_ptr];

  // NOTE: the storage array has no reset; its contents are only observable
  // through the pointers and level, which are reset below.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) begin
      mem[wr_ptr] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule : i2s_tx_fifo

// File: rtl/i2s_tx.sv
// -----------------------------------------------------------------------------
// i2s_tx
// I2S bus-master transmitter, Philips format (data one SCK after the WS edge).
// Generates SCK/WS and shifts stereo PCM MSB-first onto SD, 32 SCK per slot.
// Ports:
//   clk_i, rst_ni   : system clock, asynchronous active-low reset
//   en_i            : run enable; low forces IDLE with all pins at 0
//   flush_i         : one-cycle FIFO clear
//   prescale_i      : SCK half-period = prescale_i+1 clk cycles
//   sample_size_i   : bits per channel minus 1
//   wr_data_i       : {right, left}, each right-aligned
//   wr_valid_i      : push request; accepted while wr_ready_o
//   wr_ready_o      : FIFO not full
//   fifo_level_o    : entries held
//   empty_o         : FIFO empty
//   underflow_o     : one-cycle pulse when a frame starts with the FIFO empty
//   sck_o/ws_o/sd_o : I2S pins
// Optional (macro I2S_TX_LEVEL_IRQ_EN):
//   thresh_i, irq_en_i, irq_o : registered low-level interrupt,
//                               irq_en_i && (fifo_level_o <= thresh_i)
// -----------------------------------------------------------------------------
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int PRESCALE_W = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           en_i,
  input  logic                           flush_i,
  input  logic [PRESCALE_W-1:0]          prescale_i,
  input  logic [4:0]                     sample_size_i,
  input  logic [2*DATA_W-1:0]            wr_data_i,
  input  logic                           wr_valid_i,
  output logic                           wr_ready_o,
  output logic [fifo_aw(FIFO_DEPTH):0]   fifo_level_o,
  output logic                           empty_o,
  output logic                           underflow_o,
`ifdef I2S_TX_LEVEL_IRQ_EN
  input  logic [fifo_aw(FIFO_DEPTH):0]   thresh_i,
  input  logic                           irq_en_i,
  output logic                           irq_o,
`endif
  output logic                           sck_o,
  output logic                           ws_o,
  output logic                           sd_o
);

  localparam logic [SLOT_IDX_W-1:0] LAST_SLOT = '1;

  // ---------------------------------------------------------------------------
  // Sample FIFO
  // ---------------------------------------------------------------------------
  logic [2*DATA_W-1:0] fifo_rd_data;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_pop;

  i2s_tx_fifo #(
    .WIDTH (2*DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .flush_i   (flush_i),
    .push_i    (wr_valid_i),
    .pop_i     (fifo_pop),
    .wr_data_i (wr_data_i),
    .rd_data_o (fifo_rd_data),
    .level_o   (fifo_level_o),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign wr_ready_o = !fifo_full;
  assign empty_o    = fifo_empty;

  // ---------------------------------------------------------------------------
  // Serialiser state
  // ---------------------------------------------------------------------------
  state_e                  state;
  logic [PRESCALE_W-1:0]   presc_cnt;
  logic [PRESCALE_W-1:0]   presc_q;     // half-period length in use
  logic [SLOT_IDX_W-1:0]   slot_q;      // slot currently on the pins
  logic [DATA_W-1:0]       left_q;
  logic [DATA_W-1:0]       right_q;
  logic [BIT_W-1:0]        ss_q;        // sample size of the frame in flight

  logic                    half_done;
  logic                    fall_tick;
  logic                    frame_start;
  logic [SLOT_IDX_W-1:0]   slot_next;
  logic [SLOT_IDX_W-1:0]   slot_ws;
  logic [BIT_W-1:0]        bit_pos;
  logic [DATA_W-1:0]       left_n;
  logic [DATA_W-1:0]       right_n;
  logic [BIT_W-1:0]        ss_n;
  logic [SLOT_W-1:0]       word_ext;
  logic                    sd_n;
  logic                    ws_n;

  assign half_done   = (presc_cnt == presc_q);
  // A toggle while SCK is high is the falling edge that opens the next slot.
  assign fall_tick   = (state == RUN) && en_i && half_done && sck_o;
  assign slot_next   = slot_q + SLOT_IDX_W'(1);
  assign frame_start = fall_tick && (slot_next == '0);
  assign fifo_pop    = frame_start;

  // WS runs one slot ahead of the data it frames.
  assign slot_ws = slot_q + SLOT_IDX_W'(2);
  assign ws_n    = slot_ws[SLOT_IDX_W-1];
  assign bit_pos = slot_next[BIT_W-1:0];

  // NOTE: every signal driven here gets a default first so no latch is
  // inferred when frame_start is low.
  always_comb begin
    left_n  = left_q;
    right_n = right_q;
    ss_n    = ss_q;
    if (frame_start) begin
      ss_n = sample_size_i;
      // A flush in the same cycle wins over the pop, so that frame goes out
      // silent rather than carrying an entry the flush discarded.
      if (fifo_empty || flush_i) begin
        left_n  = '0;
        right_n = '0;
      end else begin
        right_n = fifo_rd_data[2*DATA_W-1:DATA_W];
        left_n  = fifo_rd_data[DATA_W-1:0];
      end
    end
    word_ext = SLOT_W'(slot_next[SLOT_IDX_W-1] ? right_n : left_n);
    sd_n     = (bit_pos <= ss_n) ? word_ext[ss_n - bit_pos] : 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      presc_cnt   <= '0;
      presc_q     <= '0;
      slot_q      <= LAST_SLOT;
      left_q      <= '0;
      right_q     <= '0;
      ss_q        <= '0;
      sck_o       <= 1'b0;
      ws_o        <= 1'b0;
      sd_o        <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      underflow_o <= 1'b0;
      case (state)
        IDLE: begin
          sck_o     <= 1'b0;
          ws_o      <= 1'b0;
          sd_o      <= 1'b0;
          presc_cnt <= '0;
          slot_q    <= LAST_SLOT;
          if (en_i) begin
            state   <= RUN;
            presc_q <= prescale_i;
          end
        end
        RUN: begin
          if (!en_i) begin
            // Abandon the frame in flight; the FIFO keeps its entries.
            state     <= IDLE;
            sck_o     <= 1'b0;
            ws_o      <= 1'b0;
            sd_o      <= 1'b0;
            presc_cnt <= '0;
            slot_q    <= LAST_SLOT;
          end else if (half_done) begin
            presc_cnt <= '0;
            presc_q   <= prescale_i;
            sck_o     <= ~sck_o;
            if (sck_o) begin
              slot_q      <= slot_next;
              ws_o        <= ws_n;
              sd_o        <= sd_n;
              left_q      <= left_n;
              right_q     <= right_n;
              ss_q        <= ss_n;
              underflow_o <= frame_start && fifo_empty;
            end
          end else begin
            presc_cnt <= presc_cnt + PRESCALE_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Optional FIFO low-level interrupt
  // ---------------------------------------------------------------------------
`ifdef I2S_TX_LEVEL_IRQ_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_o <= 1'b0;
    end else begin
      irq_o <= irq_en_i && (fifo_level_o <= thresh_i);
    end
  end
`else
  // Level interrupt not built.
`endif

endmodule : i2s_tx

// File: tb/tb_i2s_tx.sv
// -----------------------------------------------------------------------------
// tb_i2s_tx
// Directed, scoreboard-based bench for i2s_tx. Expected SD bits are queued per
// slot when a pair is pushed and compared at each observed SCK falling edge.
// Build with +define+I2S_TX_LEVEL_IRQ_EN to also exercise the level interrupt.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_i2s_tx;

  localparam int CLK_NS = 10;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        en_i;
  logic        flush_i;
  logic [7:0]  prescale;
  logic [4:0]  sample_size;
  logic [63:0] wr_data;
  logic        wr_valid;
  logic        wr_ready_o;
  logic [3:0]  fifo_level_o;
  logic        empty_o;
  logic        underflow_o;
  logic        sck_o;
  logic        ws_o;
  logic        sd_o;
`ifdef I2S_TX_LEVEL_IRQ_EN
  logic [3:0]  thresh;
  logic        irq_en;
  logic        irq_o;
`endif

  always #(CLK_NS/2) clk_i = ~clk_i;

  i2s_tx dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .en_i          (en_i),
    .flush_i       (flush_i),
    .prescale_i    (prescale),
    .sample_size_i (sample_size),
    .wr_data_i     (wr_data),
    .wr_valid_i    (wr_valid),
    .wr_ready_o    (wr_ready_o),
    .fifo_level_o  (fifo_level_o),
    .empty_o       (empty_o),
    .underflow_o   (underflow_o),
`ifdef I2S_TX_LEVEL_IRQ_EN
    .thresh_i      (thresh),
    .irq_en_i      (irq_en),
    .irq_o         (irq_o),
`endif
    .sck_o         (sck_o),
    .ws_o          (ws_o),
    .sd_o          (sd_o)
  );

  int   tests = 0;
  int   fails = 0;
  logic sb[$];
  time  en_time = 0;

  // Monitor: sampled on the falling clk edge, away from DUT updates.
  logic       prev_sck = 1'b0;
  int         fall_cnt = 0;
  time        fall_time = 0;
  time        prev_fall_time = 0;
  logic       mon_sd, mon_ws, mon_uf, mon_ready;
  logic [3:0] mon_lvl;
  int         uf_cycles = 0;

  always @(negedge clk_i) begin
    if (prev_sck && !sck_o) begin
      prev_fall_time <= fall_time;
      fall_time      <= $time;
      mon_sd         <= sd_o;
      mon_ws         <= ws_o;
      mon_uf         <= underflow_o;
      mon_ready      <= wr_ready_o;
      mon_lvl        <= fifo_level_o;
      fall_cnt       <= fall_cnt + 1;
    end
    prev_sck <= sck_o;
    if (underflow_o) uf_cycles <= uf_cycles + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference frame: bit per slot, MSB first, zero-padded past sample size.
  function automatic logic [63:0] frame_bits(input logic [63:0] pair, input logic [4:0] ss);
    logic [31:0] w;
    int          b;
    frame_bits = '0;
    for (int s = 0; s < 64; s++) begin
      b = s % 32;
      w = (s < 32) ? pair[31:0] : pair[63:32];
      frame_bits[s] = (b <= int'(ss)) ? w[int'(ss) - b] : 1'b0;
    end
  endfunction

  task automatic sb_push_frame(input logic [63:0] bits);
    for (int s = 0; s < 64; s++) sb.push_back(bits[s]);
  endtask

  task automatic push_pair(input logic [63:0] data, input bit to_sb);
    @(negedge clk_i);
    wr_data  = data;
    wr_valid = 1'b1;
    @(negedge clk_i);
    wr_valid = 1'b0;
    if (to_sb) sb_push_frame(frame_bits(data, sample_size));
  endtask

  task automatic wait_fall(output bit ok);
    int start;
    start = fall_cnt;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk_i);
      if (fall_cnt != start) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("sck_fall_timeout", 64'(0), 64'(1));
  endtask

  logic [3:0] lvl0;
  logic       rdy0;

  task automatic run_frame(input int first_n, input int n_slots, input bit exp_uf,
                           input bit do_push, input logic [63:0] pdata);
    bit   ok;
    logic exp_bit;
    for (int s = 0; s < n_slots; s++) begin
      wait_fall(ok);
      if (!ok) return;
      if (s == 0 && first_n > 0)
        check("first_slot_delay", 64'((fall_time - en_time) / CLK_NS), 64'(first_n));
      else
        check($sformatf("sck_period_s%0d", s), 64'((fall_time - prev_fall_time) / CLK_NS),
              64'(2 * (int'(prescale) + 1)));
      if (s == 0) begin
        check("underflow_at_slot0", 64'(mon_uf), 64'(exp_uf));
        lvl0 = mon_lvl;
        rdy0 = mon_ready;
      end
      if (sb.size() == 0) begin
        check("scoreboard_underrun", 64'(0), 64'(1));
      end else begin
        exp_bit = sb.pop_front();
        check($sformatf("sd_s%0d", s), 64'(mon_sd), 64'(exp_bit));
      end
      check($sformatf("ws_s%0d", s), 64'(mon_ws), 64'(((s + 1) % 64) >= 32));
      if (do_push && s == 10) push_pair(pdata, 1'b1);
    end
  endtask

  int uf_base;

  initial begin
    rst_ni      = 1'b0;
    en_i        = 1'b0;
    flush_i     = 1'b0;
    prescale    = 8'd1;
    sample_size = 5'd15;
    wr_data     = '0;
    wr_valid    = 1'b0;
`ifdef I2S_TX_LEVEL_IRQ_EN
    thresh      = 4'd2;
    irq_en      = 1'b1;
`endif

    // ---- Reset values --------------------------------------------------
    repeat (3) @(negedge clk_i);
    check("rst_sck", 64'(sck_o), 64'(0));
    check("rst_ws", 64'(ws_o), 64'(0));
    check("rst_sd", 64'(sd_o), 64'(0));
    check("rst_underflow", 64'(underflow_o), 64'(0));
    check("rst_level", 64'(fifo_level_o), 64'(0));
    check("rst_empty", 64'(empty_o), 64'(1));
    check("rst_ready", 64'(wr_ready_o), 64'(1));
    rst_ni = 1'b1;
    @(negedge clk_i);

    // ---- Basic frame: prescale 1, 16-bit samples -----------------------
    push_pair({32'h0000_5A5A, 32'h0000_A5F0}, 1'b1);
    check("basic_level", 64'(fifo_level_o), 64'(1));
    en_i = 1'b1;
    en_time = $time;
    // One clk to enter RUN, then 2*(prescale+1) clks to the first fall.
    run_frame(2 * (1 + 1) + 1, 64, 1'b0, 1'b0, '0);
    @(negedge clk_i);
    en_i = 1'b0;
    @(negedge clk_i);
    check("disable_sck", 64'(sck_o), 64'(0));

    // ---- Underflow: start empty, push mid-frame --------------------------
    uf_base = uf_cycles;
    sb_push_frame(64'h0);
    en_i = 1'b1;
    en_time = $time;
    run_frame(5, 64, 1'b1, 1'b1, {32'h0000_1234, 32'h0000_00C3});
    check("underflow_width", 64'(uf_cycles - uf_base), 64'(1));
    run_frame(0, 64, 1'b0, 1'b0, '0);
    check("underflow_next_level", 64'(lvl0), 64'(0));
    @(negedge clk_i);
    en_i = 1'b0;
    @(negedge clk_i);

    // ---- FIFO full: 8 pushes while idle, 9th ignored ---------------------
    prescale    = 8'd0;
    sample_size = 5'd7;
    for (int i = 0; i < 8; i++) push_pair({24'h0, 8'(8'h11 * (i + 1)), 24'h0, 8'(8'hF0 - i)}, 1'b1);
    check("full_ready", 64'(wr_ready_o), 64'(0));
    check("full_level", 64'(fifo_level_o), 64'(8));
    push_pair(64'hDEAD_BEEF_DEAD_BEEF, 1'b0);
    check("full_9th_ignored", 64'(fifo_level_o), 64'(8));
    en_i = 1'b1;
    en_time = $time;
    run_frame(3, 64, 1'b0, 1'b0, '0);
    check("full_pop_level", 64'(lvl0), 64'(7));
    check("full_pop_ready", 64'(rdy0), 64'(1));
    run_frame(0, 64, 1'b0, 1'b0, '0);
    @(negedge clk_i);
    en_i = 1'b0;
    @(negedge clk_i);
    check("full_after_two_frames", 64'(fifo_level_o), 64'(6));
    sb.delete();

    // ---- Flush, then 32-bit word and disable mid-frame -------------------
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    check("flush_level", 64'(fifo_level_o), 64'(0));
    prescale    = 8'd1;
    sample_size = 5'd31;
    push_pair({32'h1234_5678, 32'h8000_0001}, 1'b1);
    push_pair({32'hFFFF_0000, 32'h0F0F_0F0F}, 1'b1);
    en_i = 1'b1;
    en_time = $time;
    run_frame(5, 41, 1'b0, 1'b0, '0);
    @(negedge clk_i);
    en_i = 1'b0;
    @(negedge clk_i);
    check("drop_en_sck", 64'(sck_o), 64'(0));
    check("drop_en_ws", 64'(ws_o), 64'(0));
    check("drop_en_sd", 64'(sd_o), 64'(0));
    check("drop_en_level", 64'(fifo_level_o), 64'(1));
    repeat (23) void'(sb.pop_front());
    // Re-enable: fresh frame carries the retained pair.
    en_i = 1'b1;
    en_time = $time;
    run_frame(5, 64, 1'b0, 1'b0, '0);
    @(negedge clk_i);
    en_i = 1'b0;
    @(negedge clk_i);
    check("reenable_level", 64'(fifo_level_o), 64'(0));
    check("scoreboard_drained", 64'(sb.size()), 64'(0));

    // ---- Flush with a same-cycle push, 5 entries held --------------------
    for (int i = 0; i < 5; i++) push_pair(64'(i + 1), 1'b0);
    check("flush5_level_before", 64'(fifo_level_o), 64'(5));
`ifdef I2S_TX_LEVEL_IRQ_EN
    check("irq_low_above_thresh", 64'(irq_o), 64'(0));
`endif
    @(negedge clk_i);
    flush_i  = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 64'hAAAA_5555_AAAA_5555;
    @(negedge clk_i);
    flush_i  = 1'b0;
    wr_valid = 1'b0;
    check("flush_push_level", 64'(fifo_level_o), 64'(0));
    check("flush_push_empty", 64'(empty_o), 64'(1));
    @(negedge clk_i);
`ifdef I2S_TX_LEVEL_IRQ_EN
    check("irq_high_at_thresh", 64'(irq_o), 64'(1));
`endif

    // ---- Asynchronous reset mid-RUN with 3 entries held ------------------
    prescale    = 8'd0;
    sample_size = 5'd7;
    for (int i = 0; i < 4; i++) push_pair(64'h0000_00FF_0000_00FF, 1'b0);
    en_i = 1'b1;
    for (int i = 0; i < 41; i++) begin
      bit ok;
      wait_fall(ok);
      if (!ok) break;
    end
    @(negedge clk_i);
    check("midrun_level", 64'(fifo_level_o), 64'(3));
    check("midrun_ws", 64'(ws_o), 64'(1));
    @(posedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    check("arst_sck", 64'(sck_o), 64'(0));
    check("arst_ws", 64'(ws_o), 64'(0));
    check("arst_sd", 64'(sd_o), 64'(0));
    check("arst_level", 64'(fifo_level_o), 64'(0));
    check("arst_ready", 64'(wr_ready_o), 64'(1));
    check("arst_empty", 64'(empty_o), 64'(1));
    check("arst_underflow", 64'(underflow_o), 64'(0));
    en_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_i2s_tx
